// File: rtl/ifu_fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch controller
// (master) and the instruction memory or cache (slave).
interface ifu_fetch_ctrl_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata_1;
   logic [31:0] inst_rdata_2;

   modport master (
      output inst_req,
      output inst_addr,
      input  inst_addr_ok,
      input  inst_data_ok,
      input  inst_rdata_1,
      input  inst_rdata_2
   );

   modport slave (
      input  inst_req,
      input  inst_addr,
      output inst_addr_ok,
      output inst_data_ok,
      output inst_rdata_1,
      output inst_rdata_2
   );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller: issues one 8-byte-aligned fetch group at a
// time, tracks the single outstanding request and discards stale data.
module ifu_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  redirect_ena,
   input  logic [31:0]           redirect_pc,
   input  logic                  fetch_stall,
   ifu_fetch_ctrl_if.master      imem,
   output logic                  out_valid_1,
   output logic                  out_valid_2,
   output logic [31:0]           out_inst_1,
   output logic [31:0]           out_inst_2,
   output logic [31:0]           out_pc
);

   typedef enum logic [1:0] {
      S_REQ    = 2'd0,
      S_WAIT   = 2'd1,
      S_CANCEL = 2'd2
   } state_t;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [31:0] pc_r;
   logic [31:0] req_pc_r;
   logic        req_dual_r;
   logic        issue_s;
   logic        accept_s;
   logic        deliver_s;

   // A group ends at the next 8-byte boundary: an upper-word PC fetches one slot.
   function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
      logic [31:0] nxt;
      if (pc[2]) begin
         nxt = pc + 32'd4;
      end else begin
         nxt = pc + 32'd8;
      end
      return nxt;
   endfunction

   // FSM state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= S_REQ;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // PC and outstanding-request bookkeeping; redirect beats sequential advance
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pc_r       <= RESET_PC;
         req_pc_r   <= RESET_PC;
         req_dual_r <= 1'b0;
      end else begin
         if (redirect_ena) begin
            pc_r <= redirect_pc;
         end else if (accept_s) begin
            pc_r <= next_seq_pc(pc_r);
         end else begin
            pc_r <= pc_r;
         end
         if (accept_s && !redirect_ena) begin
            req_pc_r   <= pc_r;
            req_dual_r <= ~pc_r[2];
         end else begin
            req_pc_r   <= req_pc_r;
            req_dual_r <= req_dual_r;
         end
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_REQ: begin
            if (accept_s) begin
               if (redirect_ena) begin
                  state_nxt_s = S_CANCEL;
               end else begin
                  state_nxt_s = S_WAIT;
               end
            end else begin
               state_nxt_s = S_REQ;
            end
         end
         S_WAIT: begin
            if (imem.inst_data_ok) begin
               state_nxt_s = S_REQ;
            end else if (redirect_ena) begin
               state_nxt_s = S_CANCEL;
            end else begin
               state_nxt_s = S_WAIT;
            end
         end
         S_CANCEL: begin
            if (imem.inst_data_ok) begin
               state_nxt_s = S_REQ;
            end else begin
               state_nxt_s = S_CANCEL;
            end
         end
         default: begin
            state_nxt_s = S_REQ;
         end
      endcase
   end

   // FSM outputs; reset gating keeps the request and slot pulses low while held in reset
   always_comb begin
      issue_s   = resetn && (state_r == S_REQ) && !fetch_stall;
      accept_s  = issue_s && imem.inst_addr_ok;
      deliver_s = resetn && (state_r == S_WAIT) && imem.inst_data_ok && !redirect_ena;

      imem.inst_req  = issue_s;
      imem.inst_addr = pc_r;

      out_valid_1 = deliver_s;
      out_valid_2 = deliver_s && req_dual_r;
      out_pc      = req_pc_r;
      out_inst_1  = imem.inst_rdata_1;
      out_inst_2  = imem.inst_rdata_2;
   end

endmodule
